// File: rtl/bit_serial_maj_adder_ctrl.sv
// rtl/bit_serial_maj_adder_ctrl.sv - bit-serial adder built from one majority-gate full-adder cell
//
// Adds a + b + cin one bit per clock, LSB first, through a single time-shared
// majority-gate full-adder cell. The result is valid WIDTH edges after acceptance
// and is held until the consumer takes it.
//
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    in_valid/in_ready   operand handshake (a, b, cin)
//    out_valid/out_ready result handshake (sum, cout)
//    busy                high while bits are being processed
//    ovf                 signed overflow, present only with BIT_SERIAL_MAJ_ADDER_CTRL_OVERFLOW_EN
//
// Optional feature macro: BIT_SERIAL_MAJ_ADDER_CTRL_OVERFLOW_EN
`timescale 1ns/1ps
module bit_serial_maj_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef BIT_SERIAL_MAJ_ADDER_CTRL_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             c_nx, s_bit, last, accept, handshake;

   function automatic logic maj(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   // Majority-only full adder: the sum is recovered from the inverted carry-out.
   assign c_nx  = maj(a_sr[0], b_sr[0], carry);
   assign s_bit = maj(~c_nx, maj(a_sr[0], b_sr[0], ~c_nx), carry);
   assign last  = (cnt == CW'(WIDTH - 1));

   assign accept    = in_valid & in_ready;
   assign handshake = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         // Operands shift right so the current bit is always at position 0;
         // sum bits enter at the MSB and reach their final place after WIDTH steps.
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
         carry  <= c_nx;
         // Hold at the last index so the counter never wraps for power-of-two widths.
         if (!last) cnt <= cnt + 1'b1;
      end
   end

   assign sum  = sum_sr;
   assign cout = carry;

`ifdef BIT_SERIAL_MAJ_ADDER_CTRL_OVERFLOW_EN
   logic c_msb;

   // Carry entering the MSB is the carry register just before the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   c_msb <= 1'b0;
      else if (state == RUN && last) c_msb <= carry;
   end

   assign ovf = c_msb ^ carry;
`endif

endmodule

// File: tb/tb_bit_serial_maj_adder_ctrl.sv
// tb/tb_bit_serial_maj_adder_ctrl.sv - self-checking bench for bit_serial_maj_adder_ctrl
`timescale 1ns/1ps
module tb_bit_serial_maj_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         cin = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, cout, busy;
   logic [W-1:0] sum;
`ifdef BIT_SERIAL_MAJ_ADDER_CTRL_OVERFLOW_EN
   logic         ovf;
`endif

   bit_serial_maj_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout),
`ifdef BIT_SERIAL_MAJ_ADDER_CTRL_OVERFLOW_EN
      .ovf(ovf),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a transaction is idle / computing for W edges / waiting for pickup.
   bit         m_idle = 1'b1;
   bit         m_run  = 1'b0;
   bit         m_done = 1'b0;
   int         m_k    = 0;
   logic [W:0] m_res  = '0;
   bit         m_ovf  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle = 1'b1; m_run = 1'b0; m_done = 1'b0; m_k = 0;
      end else if (m_idle) begin
         if (in_valid) begin
            m_res  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            m_ovf  = (a[W-1] == b[W-1]) && (m_res[W-1] != a[W-1]);
            m_idle = 1'b0; m_run = 1'b1; m_k = 0;
         end
      end else if (m_run) begin
         m_k++;
         if (m_k == W) begin m_run = 1'b0; m_done = 1'b1; end
      end else if (m_done && out_ready) begin
         m_done = 1'b0; m_idle = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_sum_cout", {cout, sum}, 0);
      end else begin
         chk("in_ready", in_ready, m_idle);
         chk("busy", busy, m_run);
         chk("out_valid", out_valid, m_done);
         if (m_done) begin
            chk("result", {cout, sum}, m_res);
`ifdef BIT_SERIAL_MAJ_ADDER_CTRL_OVERFLOW_EN
            chk("ovf", ovf, m_ovf);
`endif
         end
      end
   end

   task automatic accept_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
      int t = 0;
      while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         return;
      end
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         out_ready = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      out_ready = 1'b0;
      if (!out_valid) chk("done_timeout", 0, 1);
   endtask

   task automatic finish_txn(input int gap);
      repeat (gap) begin
         in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   int lat;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      accept_txn(8'h35, 8'h4A, 1'b0);
      wait_done(lat);
      chk("basic_latency", lat, 8);
      chk("basic_sum", sum, 8'h7F);
      chk("basic_cout", cout, 0);
      finish_txn(0);

      accept_txn(8'hFF, 8'h00, 1'b1);
      wait_done(lat);
      chk("chain_sum", sum, 8'h00);
      chk("chain_cout", cout, 1);
`ifdef BIT_SERIAL_MAJ_ADDER_CTRL_OVERFLOW_EN
      chk("chain_ovf", ovf, 0);
`endif
      finish_txn(0);

      accept_txn(8'h7F, 8'h01, 1'b0);
      wait_done(lat);
      chk("sovf_sum", sum, 8'h80);
      chk("sovf_cout", cout, 0);
`ifdef BIT_SERIAL_MAJ_ADDER_CTRL_OVERFLOW_EN
      chk("sovf_ovf", ovf, 1);
`endif
      finish_txn(0);

      // Backpressure: result held while consumer stalls and new operands are offered.
      accept_txn(8'h12, 8'h34, 1'b0);
      wait_done(lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         @(posedge clk); #1;
         chk("bp_sum", sum, 8'h46);
         chk("bp_cout", cout, 0);
         chk("bp_in_ready", in_ready, 0);
      end
      a = 8'h10; b = 8'h20; cin = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_idle_after_hs", in_ready, 1);
      chk("bp_not_busy", busy, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_accept_next", busy, 1);
      wait_done(lat);
      chk("bp_next_sum", sum, 8'h30);
      finish_txn(0);

      // Reset after three bit steps.
      accept_txn(8'hAA, 8'h55, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rr_out_valid", out_valid, 0);
      chk("rr_in_ready", in_ready, 1);
      chk("rr_sum", sum, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      accept_txn(8'h01, 8'h01, 1'b0);
      wait_done(lat);
      chk("rr_after_sum", sum, 8'h02);
      chk("rr_latency", lat, 8);
      finish_txn(0);

      for (int n = 0; n < 1000; n++) begin
         accept_txn(W'($urandom), W'($urandom), 1'($urandom));
         wait_done(lat);
         finish_txn(int'($urandom_range(0, 4)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
